fan_power_ctrl: RTL
===================

# fan_power_ctrl

- Consumer end of the fan timer's `timeout` pulse.
- Turns speed-button presses and timer expiry into a soft-started PWM drive for the fan motor.
- Sits beside the timer block: the timer signals *when* to stop, this block decides *how* the motor is driven.
- Outputs are the motor PWM, a speed LED bar and a running flag.

## Interface
Parameters:
- `PWM_DIV`, default 10: clk cycles per PWM counter step. PWM period = 100·`PWM_DIV` cycles.
- `RAMP_DIV`, default 100_000: clk cycles per soft-start duty step of 1 %.

Ports:
- `clk` in, 1: system clock.
- `reset_p` in, 1: reset, asynchronous, active-high; clock clk.
- `btn_speed_ne` in, 1: one-cycle pulse from the button conditioner; advances the speed level.
- `timeout` in, 1: one-cycle pulse from the fan timer; forces the speed level to 0.
- `fan_pwm` out, 1: registered motor drive.
- `speed` out, 2: current speed level 0..3.
- `led_speed` out, 4: thermometer speed display.
- `running` out, 1: high whenever the FSM is not in OFF.

## Operation
- **Speed register**
  - `btn_speed_ne` increments `speed`: 0→1→2→3→0.
  - `timeout` loads 0.
  - Both in the same cycle: `timeout` wins, so `speed` = 0.
- **Target duty** `duty_tgt` (percent, 7 bits) is a combinational function of `speed`: 0→0, 1→30, 2→60, 3→100.
- **LED map** `led_speed`: 0→0000, 1→0001, 2→0011, 3→0111. It follows `speed` combinationally.
- **Ramp prescaler** is free-running, wraps at `RAMP_DIV`-1, and is never resynchronised by button or timeout.
- **Current duty** `duty_cur` (7 bits, range 0..100):
  - On each ramp tick it moves by exactly 1 toward `duty_tgt`.
  - It never overshoots.
  - It never leaves 0..100.
- **FSM states**, re-evaluated every cycle after the `duty_cur` update:
  - OFF: `duty_cur`=0 and `duty_tgt`=0.
  - RAMP_UP: `duty_cur` < `duty_tgt`.
  - RUN: `duty_cur` = `duty_tgt` ≠ 0.
  - RAMP_DOWN: `duty_cur` > `duty_tgt`.
- **Mid-ramp changes**: a new target reverses or extends the ramp from the present `duty_cur`; there is no restart from 0.
- **PWM counter** `pwm_cnt` counts 0..99, advancing once every `PWM_DIV` clk cycles.
  - `duty_lat` loads `duty_cur` only when `pwm_cnt` wraps 99→0, so no mid-period glitch.
  - `fan_pwm` = (`pwm_cnt` < `duty_lat`), registered.
  - Duty 0 gives constant low; duty 100 gives constant high.

## Timing
- **Reset values**
  - `speed`=0, `led_speed`=0000, `fan_pwm`=0, `running`=0.
  - State OFF.
  - `duty_cur`, `duty_lat`, `pwm_cnt` and both prescalers all 0.
- **Latency**
  - `btn_speed_ne` / `timeout` → `speed` and `led_speed`: 1 clk.
  - `speed` → first `duty_cur` step: next ramp tick, 1..`RAMP_DIV` cycles.
  - Full ramp 0→100: 100 ramp ticks.
  - `duty_cur` → `fan_pwm`: visible from the next PWM period boundary, plus 1 clk for the output register.
- **Boundaries**
  - Reset mid-ramp forces OFF immediately and `fan_pwm` low asynchronously.
  - A `timeout` while already OFF has no effect.
  - Back-to-back button pulses on consecutive cycles each count.

## Configuration
- Macro `FAN_SOFT_START_EN`.
- **Defined**:
  - Ramp behaviour exactly as described above.
  - RAMP_UP/RAMP_DOWN reachable.
- **Undefined**:
  - The ramp prescaler is removed.
  - `duty_cur` loads `duty_tgt` on the cycle after `speed` changes.
  - FSM passes OFF↔RUN directly; RAMP states are unreachable and `running` depends only on `duty_tgt` ≠ 0.
  - PWM-boundary latching is kept.

## Structure
- **Shared package `fan_pkg`**:
  - FSM state typedef (OFF, RAMP_UP, RUN, RAMP_DOWN).
  - Speed-level constants.
  - Duty table constants `DUTY_L1`=30, `DUTY_L2`=60, `DUTY_L3`=100.
  - `PWM_STEPS`=100.
- **Sub-module `pwm_gen_100`**: PWM prescaler, 0..99 counter, `duty_lat` boundary latch and registered comparator. Inputs are `duty_cur`; output is `fan_pwm`.
- The top level holds the speed register, ramp prescaler, `duty_cur` and the FSM.

## Test plan
Bench parameters: `PWM_DIV`=1, `RAMP_DIV`=4, `FAN_SOFT_START_EN` defined.
- **Reset**: hold `reset_p` 5 cycles → all outputs 0, state OFF. `fan_pwm` stays 0 for 1000 cycles after release.
- **Ramp up**:
  - Stimulus: one `btn_speed_ne` pulse.
  - `speed`=1 and `led_speed`=0001 after 1 clk.
  - `duty_cur` reaches 30 after 30 ramp ticks (≤124 cycles); state RUN.
  - Measured high time: 30 of every 100 cycles.
- **Full speed and wrap**:
  - Stimulus: 3 more pulses spaced 500 cycles apart.
  - Speed runs 2→3→0.
  - At 3, once `duty_cur`=100, `fan_pwm` is constant high.
  - After wrap to 0: state RAMP_DOWN, then OFF with `fan_pwm` constant low.
- **Timeout at speed 2**:
  - Stimulus: `timeout` pulse while in RUN at 60 %.
  - `speed`=0 next clk.
  - `duty_cur` decrements 1 per ramp tick to 0; `running` falls when 0 is reached.
- **Simultaneous events**: `btn_speed_ne` and `timeout` in the same cycle at `speed`=1 → `speed`=0.
- **Mid-period change**: change speed when `pwm_cnt`=50 → the current period keeps the old `duty_lat`; the new duty appears only after the 99→0 wrap.

Source files
------------

// File: rtl/fan_pkg.sv
// +----------------------------------------------------------------------+
// | fan_pkg : shared FSM states, speed levels and duty table for the fan |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package fan_pkg;

    localparam int PWM_STEPS = 100;
    localparam int DUTY_W    = 7;

    localparam logic [1:0] SPD_OFF = 2'd0;
    localparam logic [1:0] SPD_L1  = 2'd1;
    localparam logic [1:0] SPD_L2  = 2'd2;
    localparam logic [1:0] SPD_L3  = 2'd3;

    localparam logic [DUTY_W-1:0] DUTY_L1 = 7'd30;
    localparam logic [DUTY_W-1:0] DUTY_L2 = 7'd60;
    localparam logic [DUTY_W-1:0] DUTY_L3 = 7'd100;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } fan_state_t;

    function automatic logic [DUTY_W-1:0] duty_of(input logic [1:0] lvl);
        case (lvl)
            SPD_L1:  duty_of = DUTY_L1;
            SPD_L2:  duty_of = DUTY_L2;
            SPD_L3:  duty_of = DUTY_L3;
            default: duty_of = '0;
        endcase
    endfunction

    // Thermometer bar: one more lit segment per speed level.
    function automatic logic [3:0] led_of(input logic [1:0] lvl);
        case (lvl)
            SPD_L1:  led_of = 4'b0001;
            SPD_L2:  led_of = 4'b0011;
            SPD_L3:  led_of = 4'b0111;
            default: led_of = 4'b0000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_gen_100.sv
// +----------------------------------------------------------------------+
// | pwm_gen_100 : 100-step PWM with duty latched at the period boundary  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module pwm_gen_100
    import fan_pkg::*;
#(
    parameter int PWM_DIV = 10
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [DUTY_W-1:0] duty_cur_i,
    output logic              fan_pwm_o
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] lat_q, lat_d;
    logic              pwm_q, pwm_d;
    logic              w_step;
    logic              w_wrap;

    always_comb begin
        w_step = (pre_q == PRE_W'(PWM_DIV - 1));
        pre_d  = w_step ? '0 : pre_q + PRE_W'(1);
        w_wrap = w_step && (cnt_q == DUTY_W'(PWM_STEPS - 1));
        cnt_d  = cnt_q;
        if (w_step) begin
            cnt_d = w_wrap ? '0 : cnt_q + DUTY_W'(1);
        end
        // Duty only changes at the 99->0 wrap so a period is never split.
        lat_d  = w_wrap ? duty_cur_i : lat_q;
        pwm_d  = (cnt_q < lat_q);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            pre_q <= '0;
            cnt_q <= '0;
            lat_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            lat_q <= lat_d;
            pwm_q <= pwm_d;
        end
    end

    assign fan_pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/fan_power_ctrl.sv
// +----------------------------------------------------------------------+
// | fan_power_ctrl : speed register, soft-start ramp and FSM for the fan |
// | Option macro FAN_SOFT_START_EN enables the duty ramp prescaler.      |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module fan_power_ctrl
    import fan_pkg::*;
#(
    parameter int PWM_DIV  = 10,
    parameter int RAMP_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_speed_ne,
    input  logic       timeout,
    output logic       fan_pwm,
    output logic [1:0] speed,
    output logic [3:0] led_speed,
    output logic       running
);

    logic [1:0]        speed_q, speed_d;
    logic [DUTY_W-1:0] duty_cur_q, duty_cur_d;
    logic [DUTY_W-1:0] w_duty_tgt;
    logic [DUTY_W-1:0] w_duty_tgt_nx;
    fan_state_t        state_q, state_d;
    logic              running_q;

    // Timeout has priority over a coincident button press.
    always_comb begin
        speed_d = speed_q;
        if (timeout) begin
            speed_d = SPD_OFF;
        end else if (btn_speed_ne) begin
            speed_d = speed_q + 2'd1;
        end
    end

    assign w_duty_tgt    = duty_of(speed_q);
    assign w_duty_tgt_nx = duty_of(speed_d);

`ifdef FAN_SOFT_START_EN
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic              w_ramp_tick;

    always_comb begin
        w_ramp_tick = (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1));
        ramp_cnt_d  = w_ramp_tick ? '0 : ramp_cnt_q + RAMP_W'(1);
        duty_cur_d  = duty_cur_q;
        if (w_ramp_tick) begin
            if (duty_cur_q < w_duty_tgt) begin
                duty_cur_d = duty_cur_q + DUTY_W'(1);
            end else if (duty_cur_q > w_duty_tgt) begin
                duty_cur_d = duty_cur_q - DUTY_W'(1);
            end
        end
        // State follows the post-update duty so it lines up with duty_cur_q.
        if ((duty_cur_d == '0) && (w_duty_tgt_nx == '0)) begin
            state_d = ST_OFF;
        end else if (duty_cur_d < w_duty_tgt_nx) begin
            state_d = ST_RAMP_UP;
        end else if (duty_cur_d > w_duty_tgt_nx) begin
            state_d = ST_RAMP_DOWN;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Free-running: button and timeout never resynchronise the ramp.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ramp_cnt_q <= '0;
        end else begin
            ramp_cnt_q <= ramp_cnt_d;
        end
    end
`else
    always_comb begin
        duty_cur_d = w_duty_tgt;
        state_d    = (w_duty_tgt_nx != '0) ? ST_RUN : ST_OFF;
    end
`endif

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            speed_q    <= SPD_OFF;
            duty_cur_q <= '0;
            state_q    <= ST_OFF;
            running_q  <= 1'b0;
        end else begin
            speed_q    <= speed_d;
            duty_cur_q <= duty_cur_d;
            state_q    <= state_d;
            running_q  <= (state_d != ST_OFF);
        end
    end

    assign speed     = speed_q;
    assign led_speed = led_of(speed_q);
    assign running   = running_q;

    pwm_gen_100 #(
        .PWM_DIV    (PWM_DIV)
    ) u_pwm (
        .clk        (clk),
        .reset_p    (reset_p),
        .duty_cur_i (duty_cur_q),
        .fan_pwm_o  (fan_pwm)
    );

endmodule

`default_nettype wire
